// File: rtl/psram_pkg.sv
// Shared definitions for the 32-bit CPU word to 16-bit PSRAM command bridge.
package psram_pkg;

  localparam int unsigned HalfAddrW = 23;
  localparam int unsigned DataW     = 16;

  localparam logic CMD_RD = 1'b1;
  localparam logic CMD_WR = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StMerge,
    StDone
  } state_e;

  typedef struct packed {
    logic rw;
    logic hi;
  } cmd_t;

  // Enabled bytes come from the CPU write data, the rest from the halfword read back.
  function automatic logic [DataW-1:0] merge_half(input logic [DataW-1:0] wr,
                                                  input logic [DataW-1:0] rd,
                                                  input logic [1:0]       be);
    merge_half = {be[1] ? wr[15:8] : rd[15:8], be[0] ? wr[7:0] : rd[7:0]};
  endfunction

endpackage

// File: rtl/psram_cmd_issuer.sv
// Drives one registered controller command per start pulse, waits for ready,
// captures read data and aborts after a bounded wait.
module psram_cmd_issuer
  import psram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 rw,
  input  logic [HalfAddrW-1:0] addr,
  input  logic [DataW-1:0]     wdata,
  output logic                 done,
  output logic [DataW-1:0]     rdata,
  output logic                 timeout,
  input  logic                 mc_ready,
  input  logic [DataW-1:0]     mc_data_out,
  output logic                 mc_mem,
  output logic                 mc_rw,
  output logic [HalfAddrW-1:0] mc_address,
  output logic [DataW-1:0]     mc_data_in
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

  logic                 mem_q, mem_d, rw_q, rw_d;
  logic [HalfAddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0]     din_q, din_d, rdata_q, rdata_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 done_q, done_d, tmo_q, tmo_d;

  always_comb begin
    mem_d   = mem_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    if (start) begin
      mem_d  = 1'b1;
      rw_d   = rw;
      addr_d = addr;
      din_d  = wdata;
      cnt_d  = '0;
    end else if (mem_q) begin
      if (mc_ready) begin
        mem_d  = 1'b0;
        done_d = 1'b1;
      end else if (cnt_q >= CntLast) begin
        mem_d = 1'b0;
        tmo_d = 1'b1;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Controller read data is registered, so it is valid the cycle after ready.
    if (done_q && rw_q == CMD_RD) begin
      rdata_d = mc_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign done       = done_q;
  assign rdata      = rdata_q;
  assign timeout    = tmo_q;
  assign mc_mem     = mem_q;
  assign mc_rw      = rw_q;
  assign mc_address = addr_q;
  assign mc_data_in = din_q;

endmodule

// File: rtl/psram_word_bridge.sv
// Splits byte-enabled 32-bit CPU accesses into 16-bit PSRAM controller commands,
// using read-modify-write for partially enabled halfwords.
module psram_word_bridge
  import psram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [21:0]          cpu_addr,
  input  logic [3:0]           cpu_be,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic                 cpu_busy,
  input  logic                 mc_initialized,
  input  logic                 mc_ready,
  input  logic [DataW-1:0]     mc_data_out,
  output logic                 mc_mem,
  output logic                 mc_rw,
  output logic [HalfAddrW-1:0] mc_address,
  output logic [DataW-1:0]     mc_data_in
);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [21:0]            addr_q, addr_d;
  logic [3:0]             be_q, be_d;
  logic [1:0][DataW-1:0]  wr_q, wr_d;
  logic [DataW-1:0]       rd_buf_q, rd_buf_d;
  cmd_t [3:0]             list_q, list_d;
  logic [2:0]             n_q, n_d, k;
  logic [1:0]             idx_q, idx_d;
  logic                   ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic [31:0]            rdata_q, rdata_d;

  cmd_t                   cur;
  logic                   last, accept, iss_start, iss_done, iss_timeout;
  logic [DataW-1:0]       iss_rdata;

  assign cur       = list_q[idx_q];
  assign last      = (({1'b0, idx_q} + 3'd1) == n_q);
  assign accept    = (state_q == StIdle) && !busy_q && mc_initialized && cpu_req;
  assign iss_start = (state_q == StIssue);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wr_d     = wr_q;
    rd_buf_d = rd_buf_q;
    list_d   = list_q;
    n_d      = n_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    k        = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d   = cpu_we;
          addr_d = cpu_addr;
          be_d   = cpu_be;
          wr_d   = {cpu_wdata[31:16], cpu_wdata[15:0]};
          idx_d  = '0;
          list_d = '0;
          if (!cpu_we) begin
            list_d[0] = '{rw: CMD_RD, hi: 1'b0};
            list_d[1] = '{rw: CMD_RD, hi: 1'b1};
            k         = 3'd2;
          end else begin
            for (int h = 0; h < 2; h++) begin
              if (cpu_be[2*h +: 2] == 2'b11) begin
                list_d[k[1:0]] = '{rw: CMD_WR, hi: h[0]};
                k              = k + 3'd1;
              end else if (cpu_be[2*h +: 2] != 2'b00) begin
                list_d[k[1:0]]         = '{rw: CMD_RD, hi: h[0]};
                list_d[k[1:0] + 2'd1]  = '{rw: CMD_WR, hi: h[0]};
                k                      = k + 3'd2;
              end
            end
          end
          n_d     = k;
          state_d = (k == 3'd0) ? StDone : StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (iss_timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (iss_done) begin
          if (cur.rw == CMD_RD) begin
            state_d = StCapture;
          end else if (last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StIssue;
          end
        end
      end
      StCapture: begin
        rd_buf_d = iss_rdata;
        if (we_q) begin
          state_d = StMerge;
        end else if (last) begin
          rdata_d = {iss_rdata, rd_buf_q};
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StIssue;
        end
      end
      StMerge: begin
        wr_d[cur.hi] = merge_half(wr_q[cur.hi], rd_buf_q, be_q[{cur.hi, 1'b0} +: 2]);
        idx_d        = idx_q + 2'd1;
        state_d      = StIssue;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ack_d  = (state_d == StDone);
    // Busy stays up through the ack/err cycle and drops the cycle after.
    busy_d = (state_d != StIdle) || err_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wr_q     <= '0;
      rd_buf_q <= '0;
      list_q   <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      rd_buf_q <= rd_buf_d;
      list_q   <= list_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_busy  = busy_q || !mc_initialized;

  psram_cmd_issuer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_issuer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (iss_start),
    .rw         (cur.rw),
    .addr       ({addr_q, cur.hi}),
    .wdata      (wr_q[cur.hi]),
    .done       (iss_done),
    .rdata      (iss_rdata),
    .timeout    (iss_timeout),
    .mc_ready   (mc_ready),
    .mc_data_out(mc_data_out),
    .mc_mem     (mc_mem),
    .mc_rw      (mc_rw),
    .mc_address (mc_address),
    .mc_data_in (mc_data_in)
  );

endmodule

// File: tb/tb_psram_word_bridge.sv
// Directed bench for psram_word_bridge with a small PSRAM controller model.
module tb_psram_word_bridge;

  localparam int unsigned To  = 8;
  localparam int unsigned Lat = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [21:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic        mc_initialized, mc_ready;
  logic [15:0] mc_data_out, mc_data_in;
  logic        mc_mem, mc_rw;
  logic [22:0] mc_address;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  int          lat_cnt;
  logic        ready_en;
  int          rd_cnt = 0, wr_cnt = 0, ack_cnt = 0, err_cnt = 0;
  int          gap_err = 0, stab_err = 0, addr_err = 0;
  logic [7:0]  cmd_seq = 8'h0;
  logic        prev_mem, prev_ready, prev_rw;
  logic [22:0] prev_addr;
  logic [15:0] prev_din;

  always #5 clk = ~clk;

  psram_word_bridge #(
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_be        (cpu_be),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ack       (cpu_ack),
    .cpu_err       (cpu_err),
    .cpu_busy      (cpu_busy),
    .mc_initialized(mc_initialized),
    .mc_ready      (mc_ready),
    .mc_data_out   (mc_data_out),
    .mc_mem        (mc_mem),
    .mc_rw         (mc_rw),
    .mc_address    (mc_address),
    .mc_data_in    (mc_data_in)
  );

  // Controller model: ready pulse Lat+1 cycles into a request, registered read data.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mc_ready    <= 1'b0;
      mc_data_out <= 16'h0;
      lat_cnt     <= 0;
      prev_mem    <= 1'b0;
      prev_ready  <= 1'b0;
      prev_rw     <= 1'b0;
      prev_addr   <= '0;
      prev_din    <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
    end else begin
      mc_ready <= 1'b0;
      if (mc_ready) begin
        cmd_seq <= {cmd_seq[6:0], mc_rw};
        if (mc_address > 23'd255) addr_err <= addr_err + 1;
        if (mc_rw) begin
          rd_cnt      <= rd_cnt + 1;
          mc_data_out <= mem[mc_address[7:0]];
        end else begin
          wr_cnt                <= wr_cnt + 1;
          mem[mc_address[7:0]] <= mc_data_in;
        end
      end
      if (mc_mem && !mc_ready && ready_en) begin
        if (lat_cnt == Lat) begin
          mc_ready <= 1'b1;
          lat_cnt  <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else if (!mc_mem) begin
        lat_cnt <= 0;
      end
      if (prev_ready && mc_mem) gap_err <= gap_err + 1;
      if (prev_mem && mc_mem && !prev_ready &&
          ({mc_rw, mc_address, mc_data_in} !== {prev_rw, prev_addr, prev_din}))
        stab_err <= stab_err + 1;
      if (cpu_ack) ack_cnt <= ack_cnt + 1;
      if (cpu_err) err_cnt <= err_cnt + 1;
      prev_mem   <= mc_mem;
      prev_ready <= mc_ready;
      prev_rw    <= mc_rw;
      prev_addr  <= mc_address;
      prev_din   <= mc_data_in;
    end
  end

  task automatic cpu_access(input logic we, input logic [21:0] a, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic got_ack, output logic got_err, output int lat);
    int n;
    got_ack = 1'b0;
    got_err = 1'b0;
    rd      = '0;
    n       = 0;
    @(negedge clk);
    while (cpu_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_be    = be;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0;
    lat     = 1;
    n       = 0;
    while (!cpu_ack && !cpu_err && n < 300) begin
      @(negedge clk);
      n++;
      lat++;
    end
    got_ack = cpu_ack;
    got_err = cpu_err;
    rd      = cpu_rdata;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b want 1", cpu_busy);
    end
    checks++;
    if ({cpu_ack, cpu_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ack_err: got %b want 00", {cpu_ack, cpu_err});
    end
    checks++;
    if (cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00000000", cpu_rdata);
    end
    checks++;
    if ({mc_mem, mc_rw, mc_address, mc_data_in} !== 41'h0) begin
      errors++;
      $display("FAIL reset_mc: got %h want 0", {mc_mem, mc_rw, mc_address, mc_data_in});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd;
    logic        ak, er;
    int          lat, r0, w0, a0;
    r0 = rd_cnt; w0 = wr_cnt; a0 = ack_cnt;
    cpu_access(1'b1, 22'h000010, 4'b1111, 32'hDEADBEEF, rd, ak, er, lat);
    repeat (2) @(negedge clk);
    checks++;
    if (ak !== 1'b1) begin errors++; $display("FAIL wr_full_ack: got %b want 1", ak); end
    checks++;
    if (mem[8'h20] !== 16'hBEEF) begin
      errors++; $display("FAIL wr_full_lo: got %h want beef", mem[8'h20]);
    end
    checks++;
    if (mem[8'h21] !== 16'hDEAD) begin
      errors++; $display("FAIL wr_full_hi: got %h want dead", mem[8'h21]);
    end
    checks++;
    if ({wr_cnt - w0, rd_cnt - r0} !== {32'd2, 32'd0}) begin
      errors++; $display("FAIL wr_full_cmds: got wr=%0d rd=%0d want 2/0", wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if (ack_cnt - a0 !== 1) begin
      errors++; $display("FAIL wr_full_ack_count: got %0d want 1", ack_cnt - a0);
    end
    r0 = rd_cnt;
    cpu_access(1'b0, 22'h000010, 4'b0000, 32'h0, rd, ak, er, lat);
    checks++;
    if ({ak, rd} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_full: got ack=%b data=%h want 1/deadbeef", ak, rd);
    end
    checks++;
    if (rd_cnt - r0 !== 2) begin
      errors++; $display("FAIL rd_full_cmds: got %0d want 2", rd_cnt - r0);
    end
  endtask

  task automatic test_byte_rmw();
    logic [31:0] rd;
    logic        ak, er;
    int          lat, r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    cpu_access(1'b1, 22'h000010, 4'b0100, 32'h00770000, rd, ak, er, lat);
    repeat (2) @(negedge clk);
    checks++;
    if ({ak, mem[8'h21]} !== {1'b1, 16'hDE77}) begin
      errors++; $display("FAIL rmw_byte_hi: got ack=%b hi=%h want 1/de77", ak, mem[8'h21]);
    end
    checks++;
    if (mem[8'h20] !== 16'hBEEF) begin
      errors++; $display("FAIL rmw_byte_lo: got %h want beef", mem[8'h20]);
    end
    checks++;
    if ({rd_cnt - r0, wr_cnt - w0} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL rmw_byte_cmds: got rd=%0d wr=%0d want 1/1", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_both_rmw();
    logic [31:0] rd;
    logic        ak, er;
    int          lat, c0;
    c0 = rd_cnt + wr_cnt;
    cpu_access(1'b1, 22'h000011, 4'b1001, 32'h11223344, rd, ak, er, lat);
    repeat (2) @(negedge clk);
    checks++;
    if (ak !== 1'b1) begin errors++; $display("FAIL rmw_both_ack: got %b want 1", ak); end
    checks++;
    if ({rd_cnt + wr_cnt - c0, 28'h0, cmd_seq[3:0]} !== {32'd4, 32'hA}) begin
      errors++;
      $display("FAIL rmw_both_cmds: got n=%0d seq=%b want 4/1010", rd_cnt + wr_cnt - c0,
               cmd_seq[3:0]);
    end
    cpu_access(1'b0, 22'h000011, 4'b1111, 32'h0, rd, ak, er, lat);
    checks++;
    if (rd !== 32'h11000044) begin
      errors++; $display("FAIL rmw_both_data: got %h want 11000044", rd);
    end
  endtask

  task automatic test_empty_write();
    logic [31:0] rd;
    logic        ak, er;
    int          lat, c0;
    c0 = rd_cnt + wr_cnt;
    cpu_access(1'b1, 22'h000014, 4'b0000, 32'hFFFFFFFF, rd, ak, er, lat);
    repeat (2) @(negedge clk);
    checks++;
    if ({ak, lat} !== {1'b1, 32'd1}) begin
      errors++; $display("FAIL be0_ack: got ack=%b lat=%0d want 1/1", ak, lat);
    end
    checks++;
    if (rd_cnt + wr_cnt - c0 !== 0) begin
      errors++; $display("FAIL be0_cmds: got %0d want 0", rd_cnt + wr_cnt - c0);
    end
  endtask

  task automatic test_init_gating();
    int bad_busy, bad_mem, n;
    bad_busy = 0; bad_mem = 0; n = 0;
    @(negedge clk);
    mc_initialized = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 22'h000012;
    cpu_be    = 4'b1111;
    cpu_wdata = 32'hCAFEF00D;
    repeat (6) begin
      @(negedge clk);
      if (cpu_busy !== 1'b1) bad_busy++;
      if (mc_mem !== 1'b0) bad_mem++;
    end
    checks++;
    if (bad_busy !== 0) begin errors++; $display("FAIL init_busy: got %0d low cycles want 0", bad_busy); end
    checks++;
    if (bad_mem !== 0) begin errors++; $display("FAIL init_mem: got %0d mem cycles want 0", bad_mem); end
    mc_initialized = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    while (!cpu_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL init_ack: got %b want 1", cpu_ack); end
    repeat (2) @(negedge clk);
    checks++;
    if ({mem[8'h25], mem[8'h24]} !== 32'hCAFEF00D) begin
      errors++; $display("FAIL init_data: got %h want cafef00d", {mem[8'h25], mem[8'h24]});
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    logic        ak, er, seen_err, seen_ack;
    int          lat, hi, n, e0, a0;
    hi = 0; n = 0; seen_err = 1'b0; seen_ack = 1'b0;
    e0 = err_cnt; a0 = ack_cnt;
    ready_en = 1'b0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 22'h000013;
    @(negedge clk);
    cpu_req = 1'b0;
    while (!seen_err && n < 100) begin
      if (mc_mem) hi++;
      if (cpu_err) seen_err = 1'b1;
      if (cpu_ack) seen_ack = 1'b1;
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    ready_en = 1'b1;
    checks++;
    if (hi !== To) begin errors++; $display("FAIL tmo_mem_cycles: got %0d want %0d", hi, To); end
    checks++;
    if ({seen_err, seen_ack} !== 2'b10) begin
      errors++; $display("FAIL tmo_err: got err=%b ack=%b want 1/0", seen_err, seen_ack);
    end
    checks++;
    if ({err_cnt - e0, ack_cnt - a0} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL tmo_pulses: got err=%0d ack=%0d want 1/0", err_cnt - e0, ack_cnt - a0);
    end
    cpu_access(1'b0, 22'h000010, 4'b1111, 32'h0, rd, ak, er, lat);
    checks++;
    if ({ak, rd} !== {1'b1, 32'hDE77BEEF}) begin
      errors++; $display("FAIL tmo_recover: got ack=%b data=%h want 1/de77beef", ak, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_a, rd_b;
    logic        ak, er;
    int          lat, n;
    cpu_access(1'b0, 22'h000012, 4'b1111, 32'h0, rd_a, ak, er, lat);
    cpu_access(1'b0, 22'h000011, 4'b1111, 32'h0, rd_b, ak, er, lat);
    checks++;
    if ({rd_a, rd_b} !== {32'hCAFEF00D, 32'h11000044}) begin
      errors++; $display("FAIL b2b_data: got %h %h want cafef00d 11000044", rd_a, rd_b);
    end
    checks++;
    if ({gap_err, stab_err, addr_err} !== {32'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL handshake: got gap=%0d stab=%0d addr=%0d want 0/0/0", gap_err, stab_err,
               addr_err);
    end
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 22'h000010;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!mc_mem && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mc_mem, cpu_busy, cpu_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: got mem=%b busy=%b rdata=%h want 0/1/0", mc_mem, cpu_busy,
               cpu_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    mc_initialized = 1'b1;
    ready_en       = 1'b1;
    cpu_req        = 1'b0;
    cpu_we         = 1'b0;
    cpu_addr       = '0;
    cpu_be         = '0;
    cpu_wdata      = '0;
    test_reset();
    test_full_write_read();
    test_byte_rmw();
    test_both_rmw();
    test_empty_write();
    test_init_gating();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_word_bridge.md
Name: psram_word_bridge

Overview:
- Upstream neighbour of the PSRAM controller: converts 32-bit, byte-enabled CPU bus accesses into one or more 16-bit single-access commands on the controller's mem/rw/address/data_in/ready interface.
- The controller always drives both byte lanes, so partial-halfword writes are done as read-modify-write.
- Sits between the CPU/system bus and the PSRAM controller; one outstanding CPU access at a time.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles to wait for the controller's ready per command before aborting with cpu_err.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request, sampled only when cpu_busy=0
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  22  32-bit word address
- cpu_be  in  4  byte enables; bit0=bits[7:0]
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle timeout pulse, replaces cpu_ack
- cpu_busy  out  1  high from acceptance until the cycle after ack/err; also high while mc_initialized=0
- mc_initialized  in  1  controller power-up done
- mc_ready  in  1  controller one-cycle command-done pulse
- mc_data_out  in  16  controller read data, valid from the cycle after mc_ready
- mc_mem  out  1  command request (registered)
- mc_rw  out  1  1=read, 0=write (registered)
- mc_address  out  23  halfword address (registered)
- mc_data_in  out  16  write halfword (registered)

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except cpu_busy=1; latched request cleared.
- Halfword mapping is little-endian: low half = {cpu_addr,1'b0}, high half = {cpu_addr,1'b1}.
- Accept: in IDLE with mc_initialized=1 and cpu_req=1, latch we/addr/be/wdata; cpu_busy=1 from the next cycle.
- Read: always two controller reads (LO then HI); be is ignored; cpu_rdata={hi,lo}.
- Write, per half (LO first), from its two be bits:
  - 11: single write.
  - 00: half skipped, no command.
  - 01/10: read, merge enabled byte from cpu_wdata into the read halfword, then write.
  - be=0000 write: no commands; ack 1 cycle after acceptance.
- Command issue rule:
  - mc_mem, mc_rw, mc_address and mc_data_in are driven together on the cycle after the state decides to issue, and held stable until mc_ready is sampled high.
  - mc_mem drops on the clock edge at which mc_ready=1 is sampled.
  - mc_mem stays low for at least one full cycle between consecutive commands, so the controller's idle state never sees a stale request.
- Read capture: capture mc_data_out on the cycle after mc_ready (controller output register).
- States: IDLE, ISSUE, WAIT, CAPTURE, MERGE, DONE. A command list (up to 4 commands) is derived at acceptance.
- Transitions:
  - IDLE -> ISSUE.
  - ISSUE -> WAIT (mc_mem=1).
  - WAIT -> CAPTURE on mc_ready for reads, otherwise WAIT -> ISSUE (next command) or DONE.
  - CAPTURE -> MERGE if RMW, else -> ISSUE or DONE.
  - MERGE -> ISSUE.
  - DONE: cpu_ack=1 one cycle -> IDLE.
- Timeout:
  - Per-command counter, cleared at ISSUE.
  - If WAIT reaches TIMEOUT_CYCLES without mc_ready: drop mc_mem, pulse cpu_err, return to IDLE.
  - Write data for the remaining halves is discarded.
- Counter widths: timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; no wrap.
- mc_initialized falls mid-operation: do not abandon the current command; finish or time out. Block new accepts while it is low.
- Async reset mid-operation: outputs go to reset values immediately. The controller is expected to be reset by the same reset.
- cpu_rdata holds its last value outside ack; it is 0 after reset.

Decomposition:
- Shared package psram_pkg: halfword-address width 23, data width 16, state encodings, command-type constants (CMD_RD, CMD_WR).
- One sub-module: psram_cmd_issuer. It owns mc_mem/mc_rw/mc_address/mc_data_in, the ready handshake, read capture and the timeout. Interface: start, rw, addr, wdata in; done, rdata, timeout out.

Test Plan:
- Full write then read: write addr 0x000010, be=1111, wdata 0xDEADBEEF. Required: PSRAM halfword 0x20=0xBEEF, 0x21=0xDEAD, exactly 2 writes, one ack. Read of 0x000010 returns 0xDEADBEEF via 2 reads.
- Byte RMW: preload 0x21=0xDEAD; write be=0100, wdata 0x00770000. Required: LO skipped, HI read+write, 0x21=0xDE77, 2 commands total.
- Both-half RMW: be=1001 on zeroed word, wdata 0x11223344. Required: 4 commands (R,W,R,W), result 0x11000044.
- Init gating: cpu_req held while mc_initialized=0. Required: cpu_busy=1, no mc_mem until initialized rises, then normal ack.
- Timeout: TIMEOUT_CYCLES=8, controller model never asserts ready. Required: mc_mem high 8 cycles then low, cpu_err pulse, no cpu_ack, next request accepted.
- Handshake gap: back-to-back 32-bit reads. Required: mc_mem low for at least 1 cycle between each command; reset_n pulsed mid-WAIT clears mc_mem asynchronously.
